reg_file_mp: RTL and testbench

Multi-read-port successor to the single-port register file used by the FSM application datapath. It has one synchronous write port and `NUM_RD` asynchronous read ports. After reset it runs a hardware clear sweep that initialises every location to `CLEAR_VALUE` and flags `busy` while the sweep runs. It sits between the FSM controller and the datapath, so several operands can be fetched in one cycle.

---
 rtl/reg_file_mp.sv | 110 +++++++++++
 tb/tb_reg_file_mp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Register file with one synchronous write port, NUM_RD asynchronous read ports and a
// post-reset clear sweep. Define REG_FILE_MP_BYPASS_EN for write-through read forwarding.
module reg_file_mp #(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    NUM_RD      = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          address_w,
    input  logic [DATA_WIDTH-1:0]          data_w,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   address_r,
    output logic [NUM_RD*DATA_WIDTH-1:0]   data_r,
    output logic                           busy,
    output logic                           wr_drop
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH-1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    wr_drop_q, wr_drop_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_drop_d = wr_drop_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + PTR_ONE;
            if (clr_ptr_q == PTR_LAST) begin
                state_d = ST_READY;
            end
            if (we) begin
                wr_drop_d = 1'b1;
            end
        end
    end

    // The sweep owns the write port while clearing; host writes only reach memory in READY.
    always_comb begin
        busy      = (state_q == ST_CLEAR);
        mem_we    = 1'b0;
        mem_waddr = address_w;
        mem_wdata = data_w;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = CLEAR_VALUE;
        end else if (we) begin
            mem_we    = 1'b1;
        end
    end

    assign wr_drop = wr_drop_q;

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic [DATA_WIDTH-1:0] rd_word;

            assign rd_addr = address_r[gi*ADDR_WIDTH +: ADDR_WIDTH];

            // Masking during the sweep hides partially cleared contents.
            always_comb begin
                rd_word = mem[rd_addr];
                if (state_q == ST_CLEAR) begin
                    rd_word = CLEAR_VALUE;
                end
`ifdef REG_FILE_MP_BYPASS_EN
                else if (we && (rd_addr == address_w)) begin
                    rd_word = data_w;
                end
`endif
            end

            assign data_r[gi*DATA_WIDTH +: DATA_WIDTH] = rd_word;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed + randomized bench for reg_file_mp (NUM_RD=3, CLEAR_VALUE=8'hA5) against a
// behavioural model that treats the sweep as a countdown followed by a whole-array fill.
module tb_reg_file_mp;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int NR = 3;
    localparam int DEPTH = 128;
    localparam logic [DW-1:0] CV = 8'hA5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              we = 1'b0;
    logic [AW-1:0]     address_w = '0;
    logic [DW-1:0]     data_w = '0;
    logic [NR*AW-1:0]  address_r = '0;
    logic [NR*DW-1:0]  data_r;
    logic              busy;
    logic              wr_drop;

    reg_file_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RD     (NR),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .address_w(address_w),
        .data_w   (data_w),
        .address_r(address_r),
        .data_r   (data_r),
        .busy     (busy),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] mem_m [DEPTH];
    logic          busy_m = 1'b1;
    logic          wr_drop_m = 1'b0;
    int            sweep_left = DEPTH;
    logic          started = 1'b0;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (busy_m) return CV;
`ifdef REG_FILE_MP_BYPASS_EN
        if (we && a == address_w) return data_w;
`endif
        return mem_m[a];
    endfunction

    task automatic check_reads(input string tag);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s_rd%0d_a%0d", tag, p, address_r[p*AW +: AW]),
                64'(data_r[p*DW +: DW]), 64'(exp_rd(address_r[p*AW +: AW])));
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            started    = 1'b1;
            busy_m     = 1'b1;
            sweep_left = DEPTH;
            wr_drop_m  = 1'b0;
        end else if (busy_m) begin
            if (we) wr_drop_m = 1'b1;
            sweep_left--;
            if (sweep_left == 0) begin
                busy_m = 1'b0;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
            end
        end else if (we) begin
            mem_m[address_w] = data_w;
        end
    endtask

    // One clock cycle: apply inputs, check combinational reads, clock, check state.
    task automatic drive(input logic r, input logic w, input int aw, input logic [DW-1:0] dw,
                         input int a0, input int a1, input int a2);
        reset     = r;
        we        = w;
        address_w = AW'(aw);
        data_w    = dw;
        address_r = {AW'(a2), AW'(a1), AW'(a0)};
        #1;
        if (started) check_reads("pre");
        @(posedge clk);
        model_edge();
        #1;
        if (started) begin
            chk("busy", 64'(busy), 64'(busy_m));
            chk("wr_drop", 64'(wr_drop), 64'(wr_drop_m));
            check_reads("post");
        end
    endtask

    task automatic idle_rand();
        drive(1'b0, 1'b0, 0, 8'h00, $urandom_range(0, DEPTH-1),
              $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a += 3) begin
            drive(1'b0, 1'b0, 0, 8'h00, a, (a + 1) % DEPTH, (a + 2) % DEPTH);
        end
    endtask

    int n_edges;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

        // Reset held 3 cycles, then a full sweep with a dropped write in the middle.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, 8'h00, i, i + 10, i + 20);
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_wr_drop", 64'(wr_drop), 64'd0);
        n_edges = 0;
        while (busy && n_edges < 300) begin
            if (n_edges == 10) drive(1'b0, 1'b1, 5, 8'h3C, 5, 6, 7);
            else idle_rand();
            n_edges++;
        end
        chk("sweep_len", 64'(n_edges), 64'd128);
        chk("wr_drop_set", 64'(wr_drop), 64'd1);
        read_all();
        drive(1'b0, 1'b0, 0, 8'h00, 5, 5, 5);
        chk("addr5_cleared", 64'(data_r), {40'd0, CV, CV, CV});
        chk("wr_drop_sticky", 64'(wr_drop), 64'd1);

        // Multi-port read of three fresh words.
        drive(1'b0, 1'b1, 1, 8'h11, 0, 0, 0);
        drive(1'b0, 1'b1, 2, 8'h22, 0, 0, 0);
        drive(1'b0, 1'b1, 3, 8'h33, 0, 0, 0);
        address_r = {7'd3, 7'd2, 7'd1};
        #1;
        chk("multiport", 64'(data_r), 64'h332211);

        // Same-address collision on address 9.
        drive(1'b0, 1'b1, 9, 8'h44, 0, 0, 0);
        we = 1'b1; address_w = 7'd9; data_w = 8'h77; address_r = {7'd0, 7'd0, 7'd9};
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        chk("collide_before", 64'(data_r[7:0]), 64'h77);
`else
        chk("collide_before", 64'(data_r[7:0]), 64'h44);
`endif
        drive(1'b0, 1'b1, 9, 8'h77, 9, 0, 0);
        drive(1'b0, 1'b0, 0, 8'h00, 9, 9, 9);
        chk("collide_after", 64'(data_r), 64'h777777);

        // Last address and wrap to address 0.
        drive(1'b0, 1'b1, 127, 8'hFF, 127, 0, 1);
        drive(1'b0, 1'b1, 0, 8'h01, 127, 0, 1);
        drive(1'b0, 1'b0, 0, 8'h00, 127, 0, 126);
        chk("wrap_127", 64'(data_r[7:0]), 64'hFF);
        chk("wrap_0", 64'(data_r[15:8]), 64'h01);

        // Randomized traffic, biased so reads often collide with the write address.
        for (int i = 0; i < 400; i++) begin
            automatic int aw = $urandom_range(0, DEPTH-1);
            automatic int a0 = ($urandom_range(0, 3) == 0) ? aw : $urandom_range(0, DEPTH-1);
            drive(1'b0, 1'($urandom_range(0, 1)), aw, 8'($urandom),
                  a0, $urandom_range(0, DEPTH-1), aw);
        end

        // Reset from READY, reset again at sweep step 50: sweep restarts and wr_drop clears.
        drive(1'b1, 1'b0, 0, 8'h00, 1, 2, 3);
        chk("wr_drop_cleared", 64'(wr_drop), 64'd0);
        for (int i = 0; i < 50; i++) idle_rand();
        drive(1'b1, 1'b0, 0, 8'h00, 1, 2, 3);
        n_edges = 0;
        while (busy && n_edges < 300) begin
            idle_rand();
            n_edges++;
        end
        chk("resweep_len", 64'(n_edges), 64'd128);
        read_all();
        drive(1'b0, 1'b0, 0, 8'h00, 1, 9, 127);
        chk("resweep_data", 64'(data_r), {40'd0, CV, CV, CV});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
